// File: rtl/run_controller.sv
`default_nettype none
// ============================================================================
//  Module   : run_controller
//  Purpose  : Sequences a test run of one or more cores. Holds the cores in
//             reset, releases them for a bounded RUN window, ends the run when
//             the cores halt (all or any) or when the cycle budget expires,
//             pulses a register-dump strobe, then reports completion.
//  Ports    : clk          - sole clock, rising edge
//             rst          - synchronous, active-low reset
//             start        - begin a run (honoured in IDLE and DONE only)
//             halt         - per-core halt indication (honoured in RUN only)
//             core_rst     - active-high reset to the cores
//             debug        - register-dump strobe to the cores
//             done         - run finished
//             timed_out    - run ended by cycle budget rather than halt
//             cycle_count  - completed RUN cycles
//             halted_mask  - sticky record of cores that halted during RUN
//  Revision : 1.0 - initial release
// ============================================================================
module run_controller #(
  parameter int NUM_CORES      = 1,
  parameter int RST_CYCLES     = 2,
  parameter int TIMEOUT_CYCLES = 4194304,
  parameter int DEBUG_CYCLES   = 2,
  parameter int CNT_W          = 32,
  parameter int MODE_ALL       = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [NUM_CORES-1:0] halt,
  output logic                 core_rst,
  output logic                 debug,
  output logic                 done,
  output logic                 timed_out,
  output logic [CNT_W-1:0]     cycle_count,
  output logic [NUM_CORES-1:0] halted_mask
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RESET = 3'd1,
    S_RUN   = 3'd2,
    S_DUMP  = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  // Terminal values for the phase counter and the RUN cycle counter.
  localparam logic [31:0]      C_RST_LAST = 32'(RST_CYCLES - 1);
  localparam logic [31:0]      C_DBG_LAST = 32'(DEBUG_CYCLES - 1);
  localparam logic [CNT_W-1:0] C_TO_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);

  state_t                 state_q;
  logic [31:0]            phase_cnt_q;
  logic                   core_rst_q;
  logic                   debug_q;
  logic                   done_q;
  logic                   timed_out_q;
  logic [CNT_W-1:0]       cycle_count_q;
  logic [NUM_CORES-1:0]   halted_mask_q;

  logic [NUM_CORES-1:0]   halted_mask_d;
  logic [CNT_W-1:0]       cycle_count_d;
  logic                   halt_complete;

  // Completion looks at the mask including this edge's halt bits, so a core
  // halting on the final budget cycle still counts as a halt.
  assign halted_mask_d = halted_mask_q | halt;
  assign cycle_count_d = cycle_count_q + 1'b1;

  generate
    if (MODE_ALL != 0) begin : g_mode_all
      assign halt_complete = &halted_mask_d;
    end else begin : g_mode_any
      assign halt_complete = |halted_mask_d;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q       <= S_IDLE;
      phase_cnt_q   <= '0;
      core_rst_q    <= 1'b1;
      debug_q       <= 1'b0;
      done_q        <= 1'b0;
      timed_out_q   <= 1'b0;
      cycle_count_q <= '0;
      halted_mask_q <= '0;
    end else begin
      unique case (state_q)
        S_IDLE, S_DONE: begin
          if (start) begin
            state_q       <= S_RESET;
            phase_cnt_q   <= '0;
            core_rst_q    <= 1'b1;
            done_q        <= 1'b0;
            timed_out_q   <= 1'b0;
            cycle_count_q <= '0;
            halted_mask_q <= '0;
          end
        end
        S_RESET: begin
          if (phase_cnt_q == C_RST_LAST) begin
            state_q     <= S_RUN;
            phase_cnt_q <= '0;
            core_rst_q  <= 1'b0;
          end else begin
            phase_cnt_q <= phase_cnt_q + 1'b1;
          end
        end
        S_RUN: begin
          cycle_count_q <= cycle_count_d;
          halted_mask_q <= halted_mask_d;
          // Halt takes priority over timeout when both occur on one edge.
          if (halt_complete) begin
            state_q     <= S_DUMP;
            phase_cnt_q <= '0;
            debug_q     <= 1'b1;
            timed_out_q <= 1'b0;
          end else if (cycle_count_q == C_TO_LAST) begin
            state_q     <= S_DUMP;
            phase_cnt_q <= '0;
            debug_q     <= 1'b1;
            timed_out_q <= 1'b1;
          end
        end
        S_DUMP: begin
          if (phase_cnt_q == C_DBG_LAST) begin
            state_q     <= S_DONE;
            phase_cnt_q <= '0;
            debug_q     <= 1'b0;
            done_q      <= 1'b1;
            core_rst_q  <= 1'b1;
          end else begin
            phase_cnt_q <= phase_cnt_q + 1'b1;
          end
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign core_rst    = core_rst_q;
  assign debug       = debug_q;
  assign done        = done_q;
  assign timed_out   = timed_out_q;
  assign cycle_count = cycle_count_q;
  assign halted_mask = halted_mask_q;

endmodule
`default_nettype wire

// File: tb/tb_run_controller.sv
`default_nettype none
// ============================================================================
//  Module   : tb_run_controller
//  Purpose  : Directed self-checking bench for run_controller. Two instances
//             share all inputs: one ends runs when all cores halt, the other
//             when any core halts.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_run_controller;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  halt = 2'b00;

  logic        a_core_rst, a_debug, a_done, a_to;
  logic [31:0] a_cc;
  logic [1:0]  a_mask;
  logic        y_core_rst, y_debug, y_done, y_to;
  logic [31:0] y_cc;
  logic [1:0]  y_mask;

  int tests = 0;
  int failed = 0;

  always #5 clk = ~clk;

  run_controller #(
    .NUM_CORES(2), .RST_CYCLES(2), .TIMEOUT_CYCLES(10),
    .DEBUG_CYCLES(2), .CNT_W(32), .MODE_ALL(1)
  ) dut_all (
    .clk(clk), .rst(rst), .start(start), .halt(halt),
    .core_rst(a_core_rst), .debug(a_debug), .done(a_done),
    .timed_out(a_to), .cycle_count(a_cc), .halted_mask(a_mask)
  );

  run_controller #(
    .NUM_CORES(2), .RST_CYCLES(2), .TIMEOUT_CYCLES(10),
    .DEBUG_CYCLES(2), .CNT_W(32), .MODE_ALL(0)
  ) dut_any (
    .clk(clk), .rst(rst), .start(start), .halt(halt),
    .core_rst(y_core_rst), .debug(y_debug), .done(y_done),
    .timed_out(y_to), .cycle_count(y_cc), .halted_mask(y_mask)
  );

  // Outputs are observed 1 time unit after the rising edge; inputs change at
  // the same point, so they are stable for the following edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Starts a run from IDLE/DONE, drives halt bits in the given RUN cycles,
  // optionally pulses start mid-run, and checks the result through DONE.
  task automatic run_check(input string tag, input bit sel_any,
                           input int h0, input int h1, input int s_cyc,
                           input int exp_cc, input logic [1:0] exp_mask,
                           input logic exp_to);
    bit found;
    start = 1'b1;
    step();
    start = 1'b0;
    chk({tag, "_rst0"}, sel_any ? y_core_rst : a_core_rst, 1);
    chk({tag, "_done_clr"}, sel_any ? y_done : a_done, 0);
    step();
    chk({tag, "_rst1"}, sel_any ? y_core_rst : a_core_rst, 1);
    step();
    chk({tag, "_run0_rst"}, sel_any ? y_core_rst : a_core_rst, 0);
    chk({tag, "_run0_cc"}, sel_any ? y_cc : a_cc, 0);
    found = 1'b0;
    for (int c = 0; c < 20 && !found; c++) begin
      halt  = {(c == h1), (c == h0)};
      start = (c == s_cyc);
      step();
      halt  = 2'b00;
      start = 1'b0;
      if ((sel_any ? y_debug : a_debug) === 1'b1) found = 1'b1;
    end
    chk({tag, "_dump_reached"}, 32'(found), 1);
    chk({tag, "_cc"}, sel_any ? y_cc : a_cc, exp_cc);
    chk({tag, "_mask"}, sel_any ? y_mask : a_mask, exp_mask);
    chk({tag, "_to"}, sel_any ? y_to : a_to, exp_to);
    chk({tag, "_dump_rst"}, sel_any ? y_core_rst : a_core_rst, 0);
    step();
    chk({tag, "_dump1"}, sel_any ? y_debug : a_debug, 1);
    step();
    chk({tag, "_done"}, sel_any ? y_done : a_done, 1);
    chk({tag, "_done_dbg"}, sel_any ? y_debug : a_debug, 0);
    chk({tag, "_done_rst"}, sel_any ? y_core_rst : a_core_rst, 1);
    halt = 2'b11;
    step();
    halt = 2'b00;
    chk({tag, "_hold_cc"}, sel_any ? y_cc : a_cc, exp_cc);
    chk({tag, "_hold_mask"}, sel_any ? y_mask : a_mask, exp_mask);
    chk({tag, "_hold_done"}, sel_any ? y_done : a_done, 1);
  endtask

  initial begin
    bit found;

    // Reset held two edges with start and halt active.
    rst = 1'b0; start = 1'b1; halt = 2'b11;
    step();
    step();
    chk("rst_core_rst", a_core_rst, 1);
    chk("rst_debug", a_debug, 0);
    chk("rst_done", a_done, 0);
    chk("rst_to", a_to, 0);
    chk("rst_cc", a_cc, 0);
    chk("rst_mask", a_mask, 0);
    chk("rst_any_mask", y_mask, 0);
    rst = 1'b1; start = 1'b0; halt = 2'b00;
    step();
    chk("idle_core_rst", a_core_rst, 1);
    chk("idle_done", a_done, 0);

    // Timeout with start pulsed mid-run (must be ignored).
    run_check("timeout", 1'b0, -1, -1, 1, 10, 2'b00, 1'b1);
    // All-halt completes on cycle 6.
    run_check("all_halt", 1'b0, 3, 6, -1, 7, 2'b11, 1'b0);
    // Halt completion coincides with the last budget cycle.
    run_check("tie", 1'b0, 2, 9, -1, 10, 2'b11, 1'b0);
    // Any-halt instance exits on first halt.
    run_check("any_halt", 1'b1, -1, 4, -1, 5, 2'b10, 1'b0);

    // Mid-run reset, then a full run and a restart from DONE.
    rst = 1'b0;
    step();
    rst = 1'b1;
    step();
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    step();
    for (int c = 0; c < 5; c++) begin
      halt = (c == 2) ? 2'b01 : 2'b00;
      step();
      halt = 2'b00;
    end
    chk("mid_cc", a_cc, 5);
    chk("mid_mask", a_mask, 2'b01);
    rst = 1'b0;
    step();
    rst = 1'b1;
    chk("mid_rst_core_rst", a_core_rst, 1);
    chk("mid_rst_cc", a_cc, 0);
    chk("mid_rst_mask", a_mask, 0);
    chk("mid_rst_debug", a_debug, 0);
    chk("mid_rst_done", a_done, 0);

    start = 1'b1;
    step();
    start = 1'b0;
    step();
    step();
    found = 1'b0;
    for (int c = 0; c < 20 && !found; c++) begin
      halt = (c == 0) ? 2'b10 : 2'b00;
      step();
      halt = 2'b00;
      if (a_debug === 1'b1) found = 1'b1;
    end
    chk("rerun_dump_reached", 32'(found), 1);
    step();
    step();
    chk("rerun_done", a_done, 1);
    chk("rerun_to", a_to, 1);
    chk("rerun_cc", a_cc, 10);
    chk("rerun_mask", a_mask, 2'b10);
    start = 1'b1;
    step();
    start = 1'b0;
    chk("restart_done", a_done, 0);
    chk("restart_cc", a_cc, 0);
    chk("restart_mask", a_mask, 0);
    chk("restart_to", a_to, 0);
    chk("restart_core_rst", a_core_rst, 1);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire

// File: doc/run_controller.md
RUN_CONTROLLER -- requirements
Module: run_controller

Interface
REQ-001 SHALL have parameter NUM_CORES, default 1: number of core halt channels monitored.
REQ-002 SHALL have parameter RST_CYCLES, default 2: cycles core_rst is held after start (>=1).
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 4194304: maximum RUN cycles (>=1, <=2^CNT_W-1).
REQ-004 SHALL have parameter DEBUG_CYCLES, default 2: width of the debug dump pulse in cycles (>=1).
REQ-005 SHALL have parameter CNT_W, default 32: width of cycle_count.
REQ-006 SHALL have parameter MODE_ALL, default 1: 1 = run ends when all cores have halted, 0 = when any core has halted.
REQ-007 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-008 SHALL have port rst  input  1  reset, synchronous, active-low (rst=0 sampled at a clk edge resets the block).
REQ-009 SHALL have port start  input  1  begin a run; sampled only in IDLE and DONE.
REQ-010 SHALL have port halt  input  NUM_CORES  per-core halt indication; sampled only in RUN.
REQ-011 SHALL have port core_rst  output  1  active-high reset driven to the cores.
REQ-012 SHALL have port debug  output  1  register-dump strobe to the cores.
REQ-013 SHALL have port done  output  1  run finished.
REQ-014 SHALL have port timed_out  output  1  run ended by timeout, not by halt.
REQ-015 SHALL have port cycle_count  output  CNT_W  number of completed RUN cycles.
REQ-016 SHALL have port halted_mask  output  NUM_CORES  sticky record of cores that halted.

Function
REQ-017 SHALL implement states IDLE, RESET, RUN, DUMP, DONE; all outputs registered, driven from state and registers only.
REQ-018 IDLE: core_rst=1, debug=0, done=0; start=1 -> RESET, with internal counter cleared, cycle_count, halted_mask and timed_out cleared.
REQ-019 RESET: core_rst=1 for exactly RST_CYCLES cycles, then -> RUN; first RUN cycle has core_rst=0 and cycle_count=0.
REQ-020 RUN: core_rst=0; cycle_count increments by 1 on every RUN edge, including the exit edge.
REQ-021 RUN: halted_mask <= halted_mask | halt on every RUN edge.
REQ-022 RUN halt completion: MODE_ALL=1 -> all bits of (halted_mask | halt) set; MODE_ALL=0 -> any bit set; on completion -> DUMP with timed_out=0.
REQ-023 RUN timeout: cycle_count == TIMEOUT_CYCLES-1 with no completion -> DUMP with timed_out=1; RUN never exceeds TIMEOUT_CYCLES cycles.
REQ-024 Halt completion and timeout on the same edge SHALL resolve as halt: timed_out=0.
REQ-025 DUMP: debug=1, core_rst=0 for exactly DEBUG_CYCLES cycles, then -> DONE; cycle_count and halted_mask frozen.
REQ-026 DONE: done=1, debug=0, core_rst=1; cycle_count, halted_mask, timed_out held; start=1 -> RESET with same clearing as REQ-018 and done=0.
REQ-027 start SHALL be ignored in RESET, RUN and DUMP; halt SHALL be ignored outside RUN.
REQ-028 A halt bit asserted before RUN and still high on RUN edges SHALL count from the first RUN edge only.

Reset
REQ-029 rst=0 at a clk edge SHALL force, from any state including mid-RUN or mid-DUMP: state=IDLE, core_rst=1, debug=0, done=0, timed_out=0, cycle_count=0, halted_mask=0, internal counters=0.
REQ-030 While rst=0, start and halt SHALL have no effect; first state change possible on the first edge with rst=1.

Verification (NUM_CORES=2, RST_CYCLES=2, TIMEOUT_CYCLES=10, DEBUG_CYCLES=2, MODE_ALL=1 unless stated)
REQ-031 Hold rst=0 two edges with start=1, halt=2'b11 -> core_rst=1, all other outputs 0, state IDLE.
REQ-032 start pulse, no halt -> core_rst=1 for 2 cycles, RUN 10 cycles, then debug=1 for 2 cycles, done=1, timed_out=1, cycle_count=10, halted_mask=2'b00.
REQ-033 halt[0] pulsed in RUN cycle 3, halt[1] in RUN cycle 6 (cycles numbered from 0) -> exit after cycle 6, cycle_count=7, halted_mask=2'b11, timed_out=0.
REQ-034 halt[0] in cycle 2, halt[1] in cycle 9 -> cycle_count=10, timed_out=0 (halt wins tie).
REQ-035 MODE_ALL=0, halt[1] in RUN cycle 4 -> cycle_count=5, halted_mask=2'b10, timed_out=0.
REQ-036 rst=0 in RUN cycle 5 -> IDLE reset values next cycle; then run to DONE, pulse start -> fresh run with cycle_count, halted_mask, timed_out, done cleared.
